// File: rtl/dispatch_buffer_if.sv
// dispatch_buffer_if
//   Rename->dispatch and dispatch->issue-queue signal bundle for dispatch_buffer.
//   slave  : the buffer itself (captures rename lanes, presents dispatch slots).
//   master : the surrounding pipeline / testbench.
//   Signals:
//     o_stall          back-pressure to rename (rename holds while high)
//     i_squash_vld     pipeline squash, flushes the buffer
//     i_rename_vld     per-lane valid from rename
//     i_rename_info    lane payloads, lane i at [i*ENTRY_W +: ENTRY_W]
//     o_disp_vld       slot i holds the i-th oldest entry
//     o_disp_info      slot payloads, oldest in slot 0
//     i_disp_acc       per-slot acceptance from the issue-queue allocators
//     o_count          current occupancy
//   Optional (DISPBUF_PERF_EN): o_perf_stall_cyc, o_perf_empty_cyc.
interface dispatch_buffer_if #(
    parameter int RENAME_WIDTH = 4,
    parameter int DISP_WIDTH   = 4,
    parameter int DEPTH        = 16,
    parameter int ENTRY_W      = 160
);
    logic                            o_stall;
    logic                            i_squash_vld;
    logic [RENAME_WIDTH-1:0]         i_rename_vld;
    logic [RENAME_WIDTH*ENTRY_W-1:0] i_rename_info;
    logic [DISP_WIDTH-1:0]           o_disp_vld;
    logic [DISP_WIDTH*ENTRY_W-1:0]   o_disp_info;
    logic [DISP_WIDTH-1:0]           i_disp_acc;
    logic [$clog2(DEPTH):0]          o_count;
`ifdef DISPBUF_PERF_EN
    logic [31:0]                     o_perf_stall_cyc;
    logic [31:0]                     o_perf_empty_cyc;
`endif

    modport slave (
        input  i_squash_vld, i_rename_vld, i_rename_info, i_disp_acc,
        output o_stall, o_disp_vld, o_disp_info, o_count
`ifdef DISPBUF_PERF_EN
        , output o_perf_stall_cyc, o_perf_empty_cyc
`endif
    );

    modport master (
        output i_squash_vld, i_rename_vld, i_rename_info, i_disp_acc,
        input  o_stall, o_disp_vld, o_disp_info, o_count
`ifdef DISPBUF_PERF_EN
        , input o_perf_stall_cyc, o_perf_empty_cyc
`endif
    );
endinterface

// File: rtl/dispatch_buffer.sv
// dispatch_buffer
//   In-order circular buffer between rename and the issue-queue allocators.
//   Captures up to RENAME_WIDTH compacted lanes per cycle, presents the oldest
//   DISP_WIDTH entries, and retires the contiguous accepted prefix each cycle.
//   Squash (or reset) empties the buffer.
//   Ports:
//     clk  clock
//     rst  synchronous active-low reset
//     bus  dispatch_buffer_if.slave (rename lanes, stall, dispatch slots, count)
//   Build option:
//     DISPBUF_PERF_EN  adds saturating stall/empty cycle counters on the bus.
module dispatch_buffer #(
    parameter int RENAME_WIDTH = 4,
    parameter int DISP_WIDTH   = 4,
    parameter int DEPTH        = 16,
    parameter int ENTRY_W      = 160
) (
    input  logic                clk,
    input  logic                rst,
    dispatch_buffer_if.slave    bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // Stall when fewer than RENAME_WIDTH free slots remain.
    localparam logic [CNT_W-1:0] STALL_THR = CNT_W'(DEPTH - RENAME_WIDTH);

    logic [PTR_W-1:0]   head_ptr;
    logic [PTR_W-1:0]   tail_ptr;
    logic [CNT_W-1:0]   count_q;
    logic [ENTRY_W-1:0] mem [DEPTH];

    logic [CNT_W-1:0]   enq_n;
    logic [CNT_W-1:0]   deq_n;
    logic [CNT_W-1:0]   lane_off [RENAME_WIDTH];
    logic [DISP_WIDTH-1:0] disp_vld;
    logic               stall;
    logic               enq_en;
    logic               run;

    // Stall depends only on the registered count, so rename sees no
    // combinational path from its own valids or from the accepts.
    assign stall  = count_q > STALL_THR;
    assign enq_en = !bus.i_squash_vld && !stall;

    // Lane i lands at tail + (number of valid lanes below i).
    always_comb begin
        enq_n = '0;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            lane_off[i] = enq_n;
            if (bus.i_rename_vld[i]) begin
                enq_n = enq_n + CNT_W'(1);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DISP_WIDTH; i++) begin
            disp_vld[i] = CNT_W'(i) < count_q;
            bus.o_disp_info[i*ENTRY_W +: ENTRY_W] = mem[head_ptr + PTR_W'(i)];
        end
    end

    // Only the leading run of accepted valid slots retires.
    always_comb begin
        deq_n = '0;
        run   = 1'b1;
        for (int i = 0; i < DISP_WIDTH; i++) begin
            if (run && bus.i_disp_acc[i] && disp_vld[i]) begin
                deq_n = deq_n + CNT_W'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || bus.i_squash_vld) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count_q  <= '0;
        end else begin
            head_ptr <= head_ptr + deq_n[PTR_W-1:0];
            if (enq_en) begin
                tail_ptr <= tail_ptr + enq_n[PTR_W-1:0];
                count_q  <= count_q + enq_n - deq_n;
            end else begin
                count_q  <= count_q - deq_n;
            end
        end
    end

    // Payload storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (rst && enq_en) begin
            for (int i = 0; i < RENAME_WIDTH; i++) begin
                if (bus.i_rename_vld[i]) begin
                    mem[tail_ptr + lane_off[i][PTR_W-1:0]] <=
                        bus.i_rename_info[i*ENTRY_W +: ENTRY_W];
                end
            end
        end
    end

    assign bus.o_stall    = stall;
    assign bus.o_disp_vld = disp_vld;
    assign bus.o_count    = count_q;

`ifdef DISPBUF_PERF_EN
    logic [31:0] perf_stall_cyc;
    logic [31:0] perf_empty_cyc;

    // Survive squash; only reset clears them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_stall_cyc <= '0;
            perf_empty_cyc <= '0;
        end else begin
            if (stall && (|bus.i_rename_vld) && (perf_stall_cyc != '1)) begin
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
            end
            if ((count_q == '0) && (perf_empty_cyc != '1)) begin
                perf_empty_cyc <= perf_empty_cyc + 32'd1;
            end
        end
    end

    assign bus.o_perf_stall_cyc = perf_stall_cyc;
    assign bus.o_perf_empty_cyc = perf_empty_cyc;
`endif
endmodule

// File: tb/tb_dispatch_buffer.sv
module tb_dispatch_buffer;
    localparam int RW    = 4;
    localparam int DW    = 4;
    localparam int DEPTH = 16;
    localparam int W     = 160;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dispatch_buffer_if #(.RENAME_WIDTH(RW), .DISP_WIDTH(DW), .DEPTH(DEPTH), .ENTRY_W(W)) bus ();

    dispatch_buffer #(.RENAME_WIDTH(RW), .DISP_WIDTH(DW), .DEPTH(DEPTH), .ENTRY_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int seq      = 0;
    logic [W-1:0] lane_pl [RW];
    logic [W-1:0] model_q [$];
`ifdef DISPBUF_PERF_EN
    logic [31:0] m_stall_cyc = '0;
    logic [31:0] m_empty_cyc = '0;
`endif

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] new_payload();
        seq++;
        return {32'(seq), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Drive one cycle of inputs just after the edge, return at mid-cycle.
    task automatic step(input logic [RW-1:0] vld, input logic [DW-1:0] acc,
                        input logic sq, input bit fresh, input logic rst_v = 1'b1);
        @(posedge clk);
        #1;
        if (fresh) begin
            for (int i = 0; i < RW; i++) lane_pl[i] = new_payload();
        end
        for (int i = 0; i < RW; i++) bus.i_rename_info[i*W +: W] = lane_pl[i];
        bus.i_rename_vld = vld;
        bus.i_disp_acc   = acc;
        bus.i_squash_vld = sq;
        rst              = rst_v;
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] slot(input int i);
        return bus.o_disp_info[i*W +: W];
    endfunction

    // Monitor / scoreboard: compare DUT against an ordered queue of payloads,
    // then apply this cycle's inputs to the queue.
    initial begin : monitor
        int  sz;
        int  n;
        bit  exp_stall;
        @(posedge clk);
        forever begin
            @(negedge clk);
            sz        = model_q.size();
            exp_stall = (DEPTH - sz) < RW;
            chk("count", W'(bus.o_count), W'(sz));
            chk("stall", W'(bus.o_stall), W'(exp_stall));
            for (int i = 0; i < DW; i++) begin
                chk("disp_vld", W'(bus.o_disp_vld[i]), W'(i < sz));
                if (i < sz) chk("disp_info", slot(i), model_q[i]);
            end
`ifdef DISPBUF_PERF_EN
            chk("perf_stall", W'(bus.o_perf_stall_cyc), W'(m_stall_cyc));
            chk("perf_empty", W'(bus.o_perf_empty_cyc), W'(m_empty_cyc));
`endif
            if (!rst) begin
                model_q.delete();
`ifdef DISPBUF_PERF_EN
                m_stall_cyc = '0;
                m_empty_cyc = '0;
`endif
            end else begin
`ifdef DISPBUF_PERF_EN
                if (exp_stall && bus.i_rename_vld != '0 && m_stall_cyc != '1) m_stall_cyc++;
                if (sz == 0 && m_empty_cyc != '1) m_empty_cyc++;
`endif
                if (bus.i_squash_vld) begin
                    model_q.delete();
                end else begin
                    n = 0;
                    while (n < DW && n < sz && bus.i_disp_acc[n]) n++;
                    repeat (n) void'(model_q.pop_front());
                    if (!exp_stall) begin
                        for (int i = 0; i < RW; i++) begin
                            if (bus.i_rename_vld[i]) model_q.push_back(bus.i_rename_info[i*W +: W]);
                        end
                    end
                end
            end
        end
    end

    initial begin : stimulus
        logic [W-1:0] pa [RW];
        logic [W-1:0] px, py;
        logic [RW-1:0] rv;
        logic [DW-1:0] ra;
        logic          rs;
        bus.i_rename_vld  = '0;
        bus.i_disp_acc    = '0;
        bus.i_squash_vld  = 1'b0;
        bus.i_rename_info = '0;
        for (int i = 0; i < RW; i++) lane_pl[i] = '0;

        // reset then idle
        repeat (3) step('0, '0, 1'b0, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b0);
        chk("reset_count", W'(bus.o_count), W'(0));
        chk("reset_stall", W'(bus.o_stall), W'(0));
        chk("reset_vld", W'(bus.o_disp_vld), W'(0));

        // full bundle, then partial accept 1011 -> only 2 retire
        step(4'b1111, '0, 1'b0, 1'b1);
        for (int i = 0; i < RW; i++) pa[i] = lane_pl[i];
        step('0, 4'b1011, 1'b0, 1'b0);
        chk("abcd_count", W'(bus.o_count), W'(4));
        chk("abcd_vld", W'(bus.o_disp_vld), W'(4'b1111));
        for (int i = 0; i < DW; i++) chk("abcd_slot", slot(i), pa[i]);
        step('0, '0, 1'b0, 1'b0);
        chk("prefix_count", W'(bus.o_count), W'(2));
        chk("prefix_slot0", slot(0), pa[2]);
        chk("prefix_slot1", slot(1), pa[3]);
        step('0, 4'b1111, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b0);
        chk("drain_count", W'(bus.o_count), W'(0));

        // fill to full, hold a fifth bundle while stalled
        for (int b = 0; b < 4; b++) step(4'b1111, '0, 1'b0, 1'b1);
        step(4'b1111, '0, 1'b0, 1'b1);
        chk("full_count", W'(bus.o_count), W'(16));
        chk("full_stall", W'(bus.o_stall), W'(1));
        chk("full_vld", W'(bus.o_disp_vld), W'(4'b1111));
        step(4'b1111, '0, 1'b0, 1'b0);
        step(4'b1111, 4'b1111, 1'b0, 1'b0);
        chk("held_count", W'(bus.o_count), W'(16));
        step(4'b1111, '0, 1'b0, 1'b0);
        chk("after_deq_count", W'(bus.o_count), W'(12));
        chk("after_deq_stall", W'(bus.o_stall), W'(0));
        step('0, '0, 1'b0, 1'b0);
        chk("refill_count", W'(bus.o_count), W'(16));
        step('0, '0, 1'b0, 1'b0);
        chk("once_count", W'(bus.o_count), W'(16));
        repeat (4) step('0, 4'b1111, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b0);
        chk("empty_again", W'(bus.o_count), W'(0));

        // sparse lanes 1010 compact to two entries
        step(4'b1010, '0, 1'b0, 1'b1);
        px = lane_pl[1];
        py = lane_pl[3];
        step('0, '0, 1'b0, 1'b0);
        chk("sparse_count", W'(bus.o_count), W'(2));
        chk("sparse_slot0", slot(0), px);
        chk("sparse_slot1", slot(1), py);

        // build count 9, then squash with enqueue and accept in the same cycle
        step(4'b1111, '0, 1'b0, 1'b1);
        step(4'b0011, '0, 1'b0, 1'b1);
        step(4'b1000, '0, 1'b0, 1'b1);
        step(4'b1111, 4'b1111, 1'b1, 1'b1);
        chk("presquash_count", W'(bus.o_count), W'(9));
`ifdef DISPBUF_PERF_EN
        px = W'(bus.o_perf_empty_cyc);
`endif
        step('0, '0, 1'b0, 1'b0);
        chk("squash_count", W'(bus.o_count), W'(0));
        chk("squash_vld", W'(bus.o_disp_vld), W'(0));
        chk("squash_stall", W'(bus.o_stall), W'(0));
        step('0, '0, 1'b0, 1'b0);
`ifdef DISPBUF_PERF_EN
        chk("perf_empty_after_squash", W'(bus.o_perf_empty_cyc), px + W'(1));
`endif

        // randomized traffic; rename holds its bundle while stalled
        rv = '0;
        for (int c = 0; c < 400; c++) begin
            bit fresh;
            fresh = !bus.o_stall;
            if (fresh) rv = RW'($urandom_range(0, (1 << RW) - 1));
            case ($urandom_range(0, 3))
                0:       ra = '0;
                1:       ra = '1;
                default: ra = DW'($urandom_range(0, (1 << DW) - 1));
            endcase
            rs = ($urandom_range(0, 63) == 0);
            step(rv, ra, rs, fresh, (c == 200) ? 1'b0 : 1'b1);
        end

        repeat (6) step('0, 4'b1111, 1'b0, 1'b0);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
